window_minmax: RTL and testbench

WINDOW_MINMAX -- requirements
Module: window_minmax

---
 rtl/window_minmax_pkg.sv | 12 +
 rtl/eight_bit_comparator.sv | 12 +
 rtl/window_minmax.sv | 140 ++++++++++++++
 tb/tb_window_minmax.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_minmax_pkg.sv
// rtl/window_minmax_pkg.sv - shared FSM encodings and data width for window_minmax
package window_minmax_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// rtl/eight_bit_comparator.sv - unsigned 8-bit magnitude comparator (x: a>b, y: a<b)
module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       x,
  output logic       y
);

  assign x = (a > b);
  assign y = (a < b);

endmodule

// File: rtl/window_minmax.sv
// rtl/window_minmax.sv - windowed running max/min/count with valid/ready handshakes
// Optional first-occurrence indices of max/min when WINDOW_MINMAX_INDEX_EN is defined.
module window_minmax
  import window_minmax_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
`ifdef WINDOW_MINMAX_INDEX_EN
  output logic [7:0]        out_max_idx,
  output logic [7:0]        out_min_idx,
`endif
  output logic [7:0]        out_count
);

  localparam logic [7:0] WIN = 8'(WINDOW);

  state_t            state;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_q;
  logic [7:0]        count_q;
  logic [7:0]        count_next;
  logic              accept;
  logic              gt_max;
  logic              lt_min;
  logic              unused_lt_max;
  logic              unused_gt_min;
`ifdef WINDOW_MINMAX_INDEX_EN
  logic [7:0]        max_idx_q;
  logic [7:0]        min_idx_q;
`endif

  // All sample magnitude decisions come from these two comparators.
  eight_bit_comparator u_cmp_max (
    .a (in_data),
    .b (max_q),
    .x (gt_max),
    .y (unused_lt_max)
  );

  eight_bit_comparator u_cmp_min (
    .a (in_data),
    .b (min_q),
    .x (unused_gt_min),
    .y (lt_min)
  );

  assign accept     = in_valid && in_ready;
  assign count_next = count_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
`ifdef WINDOW_MINMAX_INDEX_EN
      max_idx_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            max_q   <= in_data;
            min_q   <= in_data;
            count_q <= 8'd1;
`ifdef WINDOW_MINMAX_INDEX_EN
            max_idx_q <= '0;
            min_idx_q <= '0;
`endif
            if (flush || WIN == 8'd1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (gt_max) begin
              max_q <= in_data;
`ifdef WINDOW_MINMAX_INDEX_EN
              max_idx_q <= count_q;
`endif
            end
            if (lt_min) begin
              min_q <= in_data;
`ifdef WINDOW_MINMAX_INDEX_EN
              min_idx_q <= count_q;
`endif
            end
            count_q <= count_next;
          end
          // A flush with no accepted sample still closes a non-empty window.
          if ((accept && count_next == WIN) || flush) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;
`ifdef WINDOW_MINMAX_INDEX_EN
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_window_minmax.sv
// tb/tb_window_minmax.sv - randomized and directed self-checking bench for window_minmax (WINDOW=4)
module tb_window_minmax;

  localparam int WINDOW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic [7:0] out_count;
`ifdef WINDOW_MINMAX_INDEX_EN
  logic [7:0] out_max_idx;
  logic [7:0] out_min_idx;
`endif

  int n_checks = 0;
  int n_errors = 0;

  window_minmax #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
`ifdef WINDOW_MINMAX_INDEX_EN
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of accepted samples; a result is computed when the window closes.
  int   win[$];
  bit   holding = 0;
  bit   rdy_exp = 0;
  int   e_max, e_min, e_cnt, e_max_idx, e_min_idx;

  function automatic void close_window();
    e_max = win[0]; e_min = win[0]; e_max_idx = 0; e_min_idx = 0;
    foreach (win[i]) begin
      if (win[i] > e_max) begin e_max = win[i]; e_max_idx = i; end
      if (win[i] < e_min) begin e_min = win[i]; e_min_idx = i; end
    end
    e_cnt = win.size();
    win.delete();
    holding = 1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_max", out_max, 0);
      chk("rst_out_min", out_min, 0);
      chk("rst_out_count", out_count, 0);
      holding = 0;
      rdy_exp = 0;
      win.delete();
    end else begin
      chk("mon_out_valid", out_valid, holding);
      chk("mon_in_ready", in_ready, rdy_exp);
      if (holding) begin
        chk("mon_out_max", out_max, e_max);
        chk("mon_out_min", out_min, e_min);
        chk("mon_out_count", out_count, e_cnt);
`ifdef WINDOW_MINMAX_INDEX_EN
        chk("mon_max_idx", out_max_idx, e_max_idx);
        chk("mon_min_idx", out_min_idx, e_min_idx);
`endif
      end
      // Advance the model with the inputs that the next rising edge will see.
      if (holding) begin
        if (out_ready) holding = 0;
      end else begin
        if (in_valid && rdy_exp) win.push_back(int'(in_data));
        if (win.size() == WINDOW || (flush && win.size() != 0)) close_window();
      end
      rdy_exp = !holding;
    end
  end

  task automatic send(input logic [7:0] d, input logic fl);
    bit acc = 0;
    in_valid = 1'b1; in_data = d; flush = fl;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", out_count, 0);
    chk("async_rst_max", out_max, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] last_d = 8'd0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;

    // 5, 200, 17, 3: result visible right after the 4th transfer edge.
    out_ready = 1'b1;
    send(8'd5, 0); send(8'd200, 0); send(8'd17, 0); send(8'd3, 0);
    chk("d1_valid_latency", out_valid, 1);
    chk("d1_max", out_max, 200);
    chk("d1_min", out_min, 3);
    chk("d1_count", out_count, 4);
`ifdef WINDOW_MINMAX_INDEX_EN
    chk("d1_max_idx", out_max_idx, 1);
    chk("d1_min_idx", out_min_idx, 3);
`endif
    @(posedge clk); #1;
    chk("d1_drop_valid", out_valid, 0);

    // All-equal window: ties keep the first value and index.
    for (int i = 0; i < 4; i++) send(8'h80, 0);
    chk("d2_max", out_max, 128);
    chk("d2_min", out_min, 128);
`ifdef WINDOW_MINMAX_INDEX_EN
    chk("d2_max_idx", out_max_idx, 0);
    chk("d2_min_idx", out_min_idx, 0);
`endif
    @(posedge clk); #1;

    // Backpressure for 10 cycles in HOLD.
    out_ready = 1'b0;
    send(8'd1, 0); send(8'd4, 0); send(8'd2, 0); send(8'd3, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("d3_hold_valid", out_valid, 1);
      chk("d3_hold_ready", in_ready, 0);
      chk("d3_hold_max", out_max, 4);
      chk("d3_hold_min", out_min, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("d3_release_valid", out_valid, 0);
    chk("d3_release_ready", in_ready, 1);

    // Extremes closed early by flush alongside the 0x00 sample.
    send(8'hFF, 0); send(8'h00, 1);
    chk("d4_valid", out_valid, 1);
    chk("d4_max", out_max, 255);
    chk("d4_min", out_min, 0);
    chk("d4_count", out_count, 2);
    @(posedge clk); #1;

    // Flush on an empty window does nothing.
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("d5_no_result", out_valid, 0);
    end
    flush = 1'b0;

    // Reset mid-window discards the partial result.
    send(8'd50, 0); send(8'd60, 0);
    reset_pulse();
    send(8'd9, 0); send(8'd8, 0); send(8'd7, 0); send(8'd6, 0);
    chk("d6_max", out_max, 9);
    chk("d6_min", out_min, 6);
    chk("d6_count", out_count, 4);
    @(posedge clk); #1;

    // Randomized traffic checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0: in_data = 8'h00;
        1: in_data = 8'hFF;
        2: in_data = last_d;
        default: in_data = 8'($urandom);
      endcase
      last_d    = in_data;
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
